// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_ctrl slice.
//   fifo_depth(aw)   - number of RAM words addressed by an aw-bit address.
//   occ_width(aw)    - bits needed to hold an occupancy of 0..depth (aw+1).
//   fifo_occ_t       - occupancy/pointer type for the default 4-bit address.
package fifo_pkg;

    localparam int FIFO_DEFAULT_AW = 4;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int occ_width(input int aw);
        return aw + 1;
    endfunction

    typedef logic [FIFO_DEFAULT_AW:0] fifo_occ_t;

endpackage

// File: rtl/dpram.sv
// dpram: simple dual-ported RAM, one synchronous write port and one
// combinational (asynchronous) read port, single clock.
//   clock          - write clock
//   write_enable   - store write_data at write_address on the rising edge
//   write_address  - write port address
//   write_data     - word to store
//   read_address   - read port address
//   read_data      - word at read_address, combinational
// Contents are not reset; they are undefined until written.
module dpram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock show-ahead FIFO controller around dpram.
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   clear          - synchronous flush (same register effect as reset)
//   in_data/in_valid/in_ready    - producer side
//   out_data/out_valid/out_ready - consumer side, head word shown ahead
//   count          - occupancy 0..depth
//   full/empty/almost_full - status from registered state only
//   high_water     - largest occupancy since the last reset/clear
//
// Handshake: a word moves on a side only in a cycle where both valid and
// ready are high at the rising edge; the sender holds data and valid stable
// until that happens. in_ready and out_valid depend only on registered
// pointers, never on in_valid or out_ready.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int ALMOST_FULL_LEVEL = 2**ADDRESS_WIDTH - 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_WIDTH:0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [ADDRESS_WIDTH:0]  high_water
);

    localparam int OCC_W = occ_width(ADDRESS_WIDTH);

    typedef logic [OCC_W-1:0] ptr_t;

    localparam ptr_t AF_LEVEL = ptr_t'(ALMOST_FULL_LEVEL);

    ptr_t wr_ptr, rd_ptr;
    ptr_t count_q, high_water_q;
    ptr_t wr_next, rd_next, count_next;
    logic push, pop;

    // Pointers carry one extra wrap bit so equal low bits can be told apart
    // as empty (wrap bits equal) or full (wrap bits differ).
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0])
                    && (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign wr_next    = wr_ptr + ptr_t'(push);
    assign rd_next    = rd_ptr + ptr_t'(pop);
    // Modular difference stays correct across the wrap bit.
    assign count_next = wr_next - rd_next;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            high_water_q <= '0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            count_q <= count_next;
            if (count_next > high_water_q) begin
                high_water_q <= count_next;
            end
        end
    end

    assign count       = count_q;
    assign high_water  = high_water_q;
    assign almost_full = (count_q >= AF_LEVEL);

    dpram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clock         (clock),
        .write_enable  (push),
        .write_address (wr_ptr[ADDRESS_WIDTH-1:0]),
        .write_data    (in_data),
        .read_address  (rd_ptr[ADDRESS_WIDTH-1:0]),
        .read_data     (out_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   high_water;

    fifo_ctrl #(
        .DATA_WIDTH        (DW),
        .ADDRESS_WIDTH     (AW),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .high_water  (high_water)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // scoreboard: reference contents of the FIFO, oldest first
    logic [DW-1:0] exp_q[$];
    int            exp_hw = 0;
    int            tests_run = 0;
    int            tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check_eq({tag, ".count"},       32'(count),       32'(n));
        check_eq({tag, ".empty"},       32'(empty),       32'(n == 0));
        check_eq({tag, ".full"},        32'(full),        32'(n == DEPTH));
        check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFL));
        check_eq({tag, ".in_ready"},    32'(in_ready),    32'(n != DEPTH));
        check_eq({tag, ".out_valid"},   32'(out_valid),   32'(n != 0));
        check_eq({tag, ".high_water"},  32'(high_water),  32'(exp_hw));
        if (n != 0) begin
            check_eq({tag, ".out_data"}, 32'(out_data), 32'(exp_q[0]));
        end
    endtask

    // driver: apply one cycle of inputs, advance the model on the edge, check
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic c);
        bit do_push, do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        do_pop  = r && (exp_q.size() != 0);
        do_push = v && (exp_q.size() != DEPTH);
        @(posedge clock);
        if (c) begin
            exp_q.delete();
            exp_hw = 0;
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
            if (exp_q.size() > exp_hw) exp_hw = exp_q.size();
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_hw = 0;
        check_state("reset");
    endtask

    initial begin
        logic          hold_v;
        logic [DW-1:0] hold_d;
        logic          rv, rr, rc;
        logic [DW-1:0] rd;
        bit            accepted;

        @(posedge clock);
        #1;
        do_reset();

        // fill: out_valid follows one cycle after the first push
        cycle("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("af_at_3", 32'(almost_full), 32'd1);
        cycle("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
        check_eq("full_at_4", 32'(full), 32'd1);
        cycle("fill_reject", 1'b1, 8'h55, 1'b0, 1'b0);

        // drain
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_data", 32'(out_data), 32'(8'h11 * (i + 1)));
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_eq("drain_hw", 32'(high_water), 32'd4);

        // wrap with concurrent traffic at count = 2
        cycle("pre_wrap0", 1'b1, 8'hE0, 1'b0, 1'b0);
        cycle("pre_wrap1", 1'b1, 8'hE1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("wrap", 1'b1, 8'(i), 1'b1, 1'b0);
            check_eq("wrap_count", 32'(count), 32'd2);
        end

        // full-edge simultaneity: only the pop happens
        cycle("refill0", 1'b1, 8'hC0, 1'b0, 1'b0);
        cycle("refill1", 1'b1, 8'hC1, 1'b0, 1'b0);
        check_eq("edge_full", 32'(full), 32'd1);
        cycle("edge_pop", 1'b1, 8'hC2, 1'b1, 1'b0);
        check_eq("edge_count", 32'(count), 32'd3);
        check_eq("edge_in_ready", 32'(in_ready), 32'd1);

        // clear mid-stream at count 3 with concurrent push/pop
        cycle("clear", 1'b1, 8'hAA, 1'b1, 1'b1);
        check_eq("clear_empty", 32'(empty), 32'd1);
        cycle("post_clear", 1'b1, 8'hBB, 1'b0, 1'b0);
        check_eq("post_clear_head", 32'(out_data), 32'h0000_00BB);

        // randomized traffic; producer holds an unaccepted word
        hold_v = 1'b0;
        hold_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (hold_v) begin
                rv = 1'b1;
                rd = hold_d;
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rd = 8'($urandom_range(0, 255));
            end
            rr = ($urandom_range(0, 2) != 0);
            if (i > 200) rr = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 49) == 0);
            accepted = rv && (exp_q.size() != DEPTH) && !rc;
            hold_v = rv && !accepted && !rc;
            hold_d = rd;
            cycle("rand", rv, rd, rr, rc);
        end

        // mid-stream reset
        cycle("pre_reset", 1'b1, 8'h5A, 1'b0, 1'b0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
